irq_ctrl8: RTL and testbench
============================

Name: irq_ctrl8

Overview:
8-line interrupt controller for the CPU core. Latches interrupt requests, applies a mask and fixed priority, and presents a 3-bit vector index with a req/ack handshake. It tracks one in-service interrupt until end-of-interrupt (EOI). The registered irq_idx drives the downstream 3-to-8 one-hot decoder that generates per-line ack/clear strobes.

Parameters:
NUM_IRQ, 8, number of interrupt lines; fixed at 8, the index is 3 bits.
EDGE_MODE, 8'hFF, per-line trigger mode: 1 = rising-edge, 0 = level-high.

Ports:
clk  in  1  system clock, rising edge.
rst  in  1  reset, asynchronous, active-high.
irq_in  in  8  raw interrupt lines, synchronous to clk.
mask  in  8  1 = line masked (not eligible for selection; still latches pending).
irq_ack  in  1  CPU accepts the presented interrupt.
eoi  in  1  CPU finished servicing the current interrupt.
irq_req  out  1  interrupt request to the CPU.
irq_idx  out  3  index of the requested or in-service line; feeds the 3-to-8 decoder.
busy  out  1  an interrupt is in service.
pending  out  8  latched pending bits.
in_service  out  8  one-hot in-service bit (at most one set).

Behaviour:
- Reset (async, any time including mid-handshake):
  - State goes to IDLE immediately.
  - irq_req=0, irq_idx=0, busy=0, pending=0, in_service=0, edge history=0.
- Edge lines (EDGE_MODE[i]=1): pending[i] sets on the clock edge where irq_in[i]=1 and the previous sample was 0.
- Level lines (EDGE_MODE[i]=0): pending[i] sets on any clock edge where irq_in[i]=1 and in_service[i]=0.
- Pending clear: pending[i] clears only on acceptance of line i. If a set condition occurs in the same cycle as the ack, set wins and pending stays 1.
- Eligible vector = pending & ~mask. Priority is fixed: lowest index wins.
- FSM states: IDLE, REQ, SERVICE.
  - IDLE: if eligible != 0, latch the winner into irq_idx and go to REQ; irq_req=1 from the next cycle.
  - REQ:
    - irq_idx is held stable; no preemption by higher-priority arrivals.
    - On irq_ack: clear pending[irq_idx], set in_service[irq_idx], go to SERVICE, irq_req=0.
    - If mask[irq_idx] becomes 1 before ack: withdraw, go to IDLE, irq_req=0 next cycle, pending retained.
    - If irq_ack and the mask rise coincide, ack wins.
  - SERVICE:
    - busy=1 and irq_idx is held.
    - On eoi: clear in_service and go to IDLE.
    - A new selection is possible from the cycle after IDLE is entered (no nesting).
- Ignored inputs: irq_ack outside REQ; eoi outside SERVICE.
- Latency: irq_in rising at the sample edge E0 gives pending=1 after E0 and irq_req=1 after E1. Two clocks minimum from irq_in to irq_req.
- Back-to-back: after EOI, the next eligible interrupt is requested no earlier than two edges after the EOI edge (IDLE, then REQ).
- All outputs are registered; no combinational path from inputs to outputs.

Decomposition:
- Package irq_pkg holds:
  - NUM_IRQ=8 and IDX_W=3.
  - The FSM state typedef (IDLE/REQ/SERVICE, 2 bits).
  - Default EDGE_MODE.
- One sub-module: prio_enc8, an 8-to-3 lowest-index-first priority encoder with a valid output. It is combinational and the functional inverse of the downstream decoder.

Test Plan:
- Reset then single edge: irq_in=8'h20 pulse → irq_req=1 two clocks later, irq_idx=5. Ack → pending=0, in_service=8'h20, busy=1. EOI → busy=0, in_service=0.
- Priority: irq_in=8'h90 same cycle → irq_idx=4. After ack+EOI, the second request gives irq_idx=7.
- Masking: mask=8'h01 with irq_in=8'h01 → no irq_req, pending=8'h01. Clear mask → irq_req=1, irq_idx=0.
- Withdrawal: in REQ with irq_idx=3, raise mask[3] → irq_req=0 next cycle, pending[3] still 1. No in_service bit set.
- Level re-trigger: EDGE_MODE=8'h00, hold irq_in[2]=1 through ack and EOI → pending[2] re-sets after EOI and a second request with irq_idx=2 appears.
- Async reset mid-SERVICE: assert rst between edges → irq_req, busy, pending and in_service read 0 before the next clk edge. Spurious irq_ack/eoi in IDLE cause no change.

Source files
------------

// File: rtl/irq_pkg.sv
// irq_pkg: shared constants and FSM state type for the 8-line interrupt controller
package irq_pkg;
  localparam int NUM_IRQ = 8;
  localparam int IDX_W = 3;
  localparam logic [NUM_IRQ-1:0] EDGE_MODE_DEF = 8'hFF;
  typedef enum logic [1:0] {IDLE, REQ, SERVICE} state_t;
endpackage

// File: rtl/prio_enc8.sv
// prio_enc8: 8-to-3 priority encoder, lowest set index wins
module prio_enc8
  import irq_pkg::*;
(
  input  logic [NUM_IRQ-1:0] vec,
  output logic [IDX_W-1:0]   idx,
  output logic               valid
);
  always_comb begin
    valid = |vec;
    idx = '0;
    for (int i = NUM_IRQ - 1; i >= 0; i--) if (vec[i]) idx = IDX_W'(i);
  end
endmodule

// File: rtl/irq_ctrl8.sv
// irq_ctrl8: latches requests, masks, prioritises and hands one interrupt at a time to the CPU
module irq_ctrl8
  import irq_pkg::*;
#(
  parameter logic [NUM_IRQ-1:0] EDGE_MODE = EDGE_MODE_DEF
) (
  input  logic               clk,
  input  logic               rst,
  input  logic [NUM_IRQ-1:0] irq_in,
  input  logic [NUM_IRQ-1:0] mask,
  input  logic               irq_ack,
  input  logic               eoi,
  output logic               irq_req,
  output logic [IDX_W-1:0]   irq_idx,
  output logic               busy,
  output logic [NUM_IRQ-1:0] pending,
  output logic [NUM_IRQ-1:0] in_service
);
  state_t state_q, state_d;
  logic [NUM_IRQ-1:0] pending_q, pending_d, in_service_q, in_service_d, prev_q;
  logic [NUM_IRQ-1:0] set_v, elig, idx_oh;
  logic [IDX_W-1:0] irq_idx_q, irq_idx_d, win;
  logic win_v, irq_req_q, irq_req_d, busy_q, busy_d, acc;
  prio_enc8 u_enc (.vec(elig), .idx(win), .valid(win_v));
  always_comb begin
    elig = pending_q & ~mask;
    idx_oh = NUM_IRQ'(1) << irq_idx_q;
    acc = state_q == REQ && irq_ack;
    set_v = (EDGE_MODE & irq_in & ~prev_q) | (~EDGE_MODE & irq_in & ~in_service_q);
    // a new set condition in the acceptance cycle keeps the line pending
    pending_d = (pending_q & ~(acc ? idx_oh : '0)) | set_v;
    state_d = state_q;
    irq_idx_d = irq_idx_q;
    irq_req_d = irq_req_q;
    busy_d = busy_q;
    in_service_d = in_service_q;
    case (state_q)
      IDLE: if (win_v) begin
        state_d = REQ;
        irq_idx_d = win;
        irq_req_d = 1'b1;
      end
      REQ: if (irq_ack) begin
        state_d = SERVICE;
        irq_req_d = 1'b0;
        busy_d = 1'b1;
        in_service_d = idx_oh;
      end else if (mask[irq_idx_q]) begin
        state_d = IDLE;
        irq_req_d = 1'b0;
      end
      SERVICE: if (eoi) begin
        state_d = IDLE;
        busy_d = 1'b0;
        in_service_d = '0;
      end
      default: state_d = IDLE;
    endcase
  end
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q <= IDLE;
      pending_q <= '0;
      in_service_q <= '0;
      prev_q <= '0;
      irq_idx_q <= '0;
      irq_req_q <= 1'b0;
      busy_q <= 1'b0;
    end else begin
      state_q <= state_d;
      pending_q <= pending_d;
      in_service_q <= in_service_d;
      prev_q <= irq_in;
      irq_idx_q <= irq_idx_d;
      irq_req_q <= irq_req_d;
      busy_q <= busy_d;
    end
  end
  assign irq_req = irq_req_q;
  assign irq_idx = irq_idx_q;
  assign busy = busy_q;
  assign pending = pending_q;
  assign in_service = in_service_q;
endmodule

// File: tb/tb_irq_ctrl8.sv
// tb_irq_ctrl8: edge-mode and level-mode controllers checked every cycle against a reference model
module tb_irq_ctrl8;
  logic clk = 1'b0, rst = 1'b1, irq_ack = 1'b0, eoi = 1'b0;
  logic [7:0] irq_in = '0, mask = '0;
  logic req_o[2], busy_o[2];
  logic [2:0] idx_o[2];
  logic [7:0] pend_o[2], isv_o[2];
  int n_chk = 0, n_err = 0;
  bit [7:0] em[2] = '{8'hFF, 8'h00};
  bit [7:0] m_pend[2], m_prev[2], m_isv[2];
  bit m_req[2], m_busy[2];
  int m_idx[2];

  always #5 clk = ~clk;

  irq_ctrl8 #(.EDGE_MODE(8'hFF)) u_edge (
    .clk(clk), .rst(rst), .irq_in(irq_in), .mask(mask), .irq_ack(irq_ack), .eoi(eoi),
    .irq_req(req_o[0]), .irq_idx(idx_o[0]), .busy(busy_o[0]), .pending(pend_o[0]), .in_service(isv_o[0]));
  irq_ctrl8 #(.EDGE_MODE(8'h00)) u_level (
    .clk(clk), .rst(rst), .irq_in(irq_in), .mask(mask), .irq_ack(irq_ack), .eoi(eoi),
    .irq_req(req_o[1]), .irq_idx(idx_o[1]), .busy(busy_o[1]), .pending(pend_o[1]), .in_service(isv_o[1]));

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_chk++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h at %0t", tag, got, exp, $time);
    end
  endtask

  task automatic model_reset();
    for (int k = 0; k < 2; k++) begin
      m_pend[k] = 0; m_prev[k] = 0; m_isv[k] = 0;
      m_req[k] = 0; m_busy[k] = 0; m_idx[k] = 0;
    end
  endtask

  task automatic model_step();
    for (int k = 0; k < 2; k++) begin
      bit [7:0] set, nxt, elig;
      for (int i = 0; i < 8; i++)
        set[i] = em[k][i] ? (irq_in[i] && !m_prev[k][i]) : (irq_in[i] && !m_isv[k][i]);
      nxt = m_pend[k];
      if (m_req[k] && irq_ack) nxt[m_idx[k]] = 1'b0;
      nxt |= set;
      elig = m_pend[k] & ~mask;
      if (!m_req[k] && !m_busy[k]) begin
        if (elig != 0) begin
          m_idx[k] = $clog2(int'(elig & (~elig + 8'd1)));
          m_req[k] = 1;
        end
      end else if (m_req[k]) begin
        if (irq_ack) begin
          m_req[k] = 0; m_busy[k] = 1; m_isv[k] = 8'd1 << m_idx[k];
        end else if (mask[m_idx[k]]) m_req[k] = 0;
      end else if (eoi) begin
        m_busy[k] = 0; m_isv[k] = 0;
      end
      m_pend[k] = nxt;
      m_prev[k] = irq_in;
    end
  endtask

  task automatic compare_all();
    for (int k = 0; k < 2; k++) begin
      check($sformatf("req%0d", k), 32'(req_o[k]), 32'(m_req[k]));
      check($sformatf("idx%0d", k), 32'(idx_o[k]), 32'(m_idx[k]));
      check($sformatf("busy%0d", k), 32'(busy_o[k]), 32'(m_busy[k]));
      check($sformatf("pend%0d", k), 32'(pend_o[k]), 32'(m_pend[k]));
      check($sformatf("isv%0d", k), 32'(isv_o[k]), 32'(m_isv[k]));
    end
  endtask

  task automatic cyc(input logic [7:0] i, input logic [7:0] m, input logic a, input logic e);
    irq_in = i; mask = m; irq_ack = a; eoi = e;
    @(posedge clk);
    model_step();
    @(negedge clk);
    compare_all();
  endtask

  task automatic do_reset();
    rst = 1'b1;
    #1;
    model_reset();
    compare_all();
    @(negedge clk);
    rst = 1'b0;
  endtask

  initial begin
    model_reset();
    @(negedge clk);
    compare_all();
    rst = 1'b0;
    // single edge request
    cyc(8'h20, 0, 0, 0);
    check("t1_pend", 32'(pend_o[0]), 32'h20);
    cyc(0, 0, 0, 0);
    check("t1_req", 32'(req_o[0]), 1);
    check("t1_idx", 32'(idx_o[0]), 5);
    cyc(0, 0, 1, 0);
    check("t1_isv", 32'(isv_o[0]), 32'h20);
    cyc(0, 0, 0, 1);
    check("t1_busy", 32'(busy_o[0]), 0);
    // priority
    do_reset();
    cyc(8'h90, 0, 0, 0);
    cyc(0, 0, 0, 0);
    check("t2_idx4", 32'(idx_o[0]), 4);
    cyc(0, 0, 1, 0);
    cyc(0, 0, 0, 1);
    cyc(0, 0, 0, 0);
    check("t2_idx7", 32'(idx_o[0]), 7);
    check("t2_req7", 32'(req_o[0]), 1);
    cyc(0, 0, 1, 0);
    cyc(0, 0, 0, 1);
    // masking
    do_reset();
    cyc(8'h01, 8'h01, 0, 0);
    cyc(0, 8'h01, 0, 0);
    cyc(0, 8'h01, 0, 0);
    check("t3_noreq", 32'(req_o[0]), 0);
    check("t3_pend", 32'(pend_o[0]), 32'h01);
    cyc(0, 0, 0, 0);
    check("t3_req", 32'(req_o[0]), 1);
    check("t3_idx", 32'(idx_o[0]), 0);
    // withdrawal
    do_reset();
    cyc(8'h08, 0, 0, 0);
    cyc(0, 0, 0, 0);
    check("t4_idx", 32'(idx_o[0]), 3);
    cyc(0, 8'h08, 0, 0);
    check("t4_wd", 32'(req_o[0]), 0);
    check("t4_pend", 32'(pend_o[0][3]), 1);
    check("t4_isv", 32'(isv_o[0]), 0);
    cyc(0, 8'h08, 1, 0);
    cyc(0, 0, 0, 0);
    cyc(0, 0, 1, 1);
    cyc(0, 0, 0, 1);
    // level re-trigger on the level-mode instance
    do_reset();
    cyc(8'h04, 0, 0, 0);
    cyc(8'h04, 0, 0, 0);
    cyc(8'h04, 0, 1, 0);
    check("t5_busy", 32'(busy_o[1]), 1);
    cyc(8'h04, 0, 0, 0);
    cyc(8'h04, 0, 0, 1);
    cyc(8'h04, 0, 0, 0);
    check("t5_req2", 32'(req_o[1]), 1);
    check("t5_idx2", 32'(idx_o[1]), 2);
    cyc(8'h04, 0, 1, 0);
    // async reset mid-service, then spurious ack/eoi in idle
    #2;
    do_reset();
    check("t6_pend", 32'(pend_o[1]), 0);
    cyc(0, 0, 1, 1);
    cyc(0, 0, 1, 0);
    check("t6_idle", 32'(busy_o[0]), 0);
    // randomized traffic
    for (int n = 0; n < 3000; n++) begin
      if (n % 500 == 499) begin
        #($urandom_range(1, 3));
        do_reset();
      end else
        cyc(8'($urandom), $urandom_range(0, 3) == 0 ? 8'($urandom) : 8'h00,
            1'($urandom_range(0, 2) == 0), 1'($urandom_range(0, 3) == 0));
    end
    $display("Result: errors=%0d of %0d checks", n_err, n_chk);
    $finish;
  end
endmodule
